anton_neopixel_frame_scheduler: RTL and testbench
=================================================

Name: anton_neopixel_frame_scheduler

Overview:
Sequences the NeoPixel stream datapath at the 6.4 MHz pixel clock. It accepts start/stop commands from the register block and performs the initSlow/initSlowDone handshake. It drives the run enable and counts transmitted frames, stopping after one frame, after N frames or never (loop). It also owns the double-buffer bank select, swapping banks only at frame boundaries so software never tears a frame.

Parameters:
FRAME_CNT_BITS, 8, width of frame counter and frame limit.
INIT_TIMEOUT, 15, clk6_4mhz cycles allowed for initSlowDone before flagging an error.

Ports:
clk6_4mhz  input  1  pixel/stream clock, the only clock.
reset  input  1  asynchronous, active-high reset.
cmd_start  input  1  one-cycle pulse, request to begin streaming.
cmd_stop  input  1  one-cycle pulse, request to stop at the next frame boundary.
cmd_swap  input  1  one-cycle pulse, request a bank swap at the next frame boundary.
reg_ctrl_loop  input  1  1 = stream frames indefinitely.
reg_frame_limit  input  FRAME_CNT_BITS  number of frames when loop=0; 0 is treated as 1.
stream_pixel_of  input  1  last bit of the last pixel sent (from stream logic).
stream_sync_of  input  1  reset/latch delay finished (from stream logic).
initSlowDone  input  1  stream logic index reset has completed.
initSlow  output  1  request to clear the stream logic indices.
reg_ctrl_run  output  1  run enable to the stream logic.
bank_sel  output  1  active buffer bank for the stream logic to read.
busy  output  1  scheduler is not in IDLE.
frame_done  output  1  one-cycle pulse at each completed frame (on stream_sync_of).
frame_count  output  FRAME_CNT_BITS  frames completed since start; saturates.
init_err  output  1  sticky flag, init handshake timed out.

Behaviour:
- Reset values: state=IDLE; initSlow, reg_ctrl_run, bank_sel, busy, frame_done, init_err = 0; frame_count = 0. Reset mid-operation drops run immediately, with no graceful stop.
- States: IDLE, INIT, STREAM, LATCH, STOPPING.
- IDLE: on cmd_start, go to INIT, assert initSlow on the next cycle, clear frame_count, clear init_err, and start the timeout counter at 0. cmd_stop in IDLE is ignored.
- INIT: hold initSlow high until initSlowDone is sampled at 1. Then drop initSlow and go to STREAM with run=1 on the following cycle (latency from start to run = 2 cycles plus handshake).
  - If the timeout counter reaches INIT_TIMEOUT without done, set init_err and return to IDLE with initSlow=0.
- STREAM: run=1. On stream_pixel_of, go to LATCH. Run stays 1, because stream logic needs run to count the reset delay.
- LATCH: on stream_sync_of:
  - pulse frame_done and increment frame_count, saturating at all-ones.
  - if a swap is pending, toggle bank_sel and clear the pending flag (same cycle as frame_done).
  - if a stop is pending, or loop=0 and the frame_count after increment is at least max(reg_frame_limit,1), drop run and go to STOPPING.
  - otherwise return to STREAM.
- STOPPING: one cycle with run=0, then IDLE. busy=0 in IDLE only.
- cmd_stop while busy sets stop_pending; it is cleared on entering IDLE. The frame in flight always completes.
- cmd_swap sets swap_pending in any state. In IDLE it takes effect immediately (next cycle).
- cmd_start while busy is ignored.
- Simultaneous cmd_start and cmd_stop in IDLE: start wins and stop_pending is set, so exactly one frame is sent.
- stream_pixel_of outside STREAM and stream_sync_of outside LATCH are ignored.
- Comparisons are unsigned and use FRAME_CNT_BITS width.

Decomposition:
- Shared package/include (anton_common.vh):
  - state encodings ENUM_SCHED_IDLE/INIT/STREAM/LATCH/STOPPING.
  - INIT_TIMEOUT_DEFAULT and FRAME_CNT_BITS_DEFAULT.
- One natural sub-module, anton_neopixel_init_handshake: the initSlow request, done wait and timeout counter, returning done/err pulses. Everything else lives in the top FSM.

Test Plan:
1. loop=0, limit=3, cmd_start, stream model ack init after 2 cycles -> run rises; exactly 3 frame_done pulses; frame_count=3; run=0 one cycle after the 3rd sync_of; busy=0 after a further cycle.
2. loop=1, cmd_start, cmd_stop mid-frame 2 -> frame 2 completes; frame_done count=2; run drops on the 2nd sync_of; returns to IDLE.
3. initSlowDone held 0 -> after 15 cycles init_err=1, initSlow=0, state IDLE, run never asserted; next cmd_start clears init_err.
4. loop=1, cmd_swap mid-pixel-stream -> bank_sel toggles exactly on the cycle of the next frame_done; a second cmd_swap in IDLE toggles on the next cycle.
5. limit=0, loop=0 -> behaves as limit=1, one frame; cmd_start + cmd_stop same cycle -> one frame.
6. Assert reset during LATCH -> run, initSlow, bank_sel, frame_count all 0 asynchronously; no frame_done pulse.

Source files
------------

// File: rtl/anton_neopixel_frame_scheduler_pkg.sv
// Shared definitions for the NeoPixel frame scheduler.
// Holds the scheduler state encoding and the default sizing parameters.
package anton_neopixel_frame_scheduler_pkg;

    localparam int INIT_TIMEOUT_DEFAULT   = 15;
    localparam int FRAME_CNT_BITS_DEFAULT = 8;

    typedef enum logic [2:0] {
        ENUM_SCHED_IDLE     = 3'd0,
        ENUM_SCHED_INIT     = 3'd1,
        ENUM_SCHED_STREAM   = 3'd2,
        ENUM_SCHED_LATCH    = 3'd3,
        ENUM_SCHED_STOPPING = 3'd4
    } sched_state_e;

endpackage

// File: rtl/anton_neopixel_init_handshake.sv
// initSlow request / initSlowDone wait with a bounded timeout.
// Emits single-cycle done or err while the request is outstanding.
module anton_neopixel_init_handshake
    import anton_neopixel_frame_scheduler_pkg::*;
#(
    parameter int INIT_TIMEOUT = INIT_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic init_slow_done,
    output logic init_slow,
    output logic done,
    output logic err
);

    localparam int            CW   = $clog2(INIT_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(INIT_TIMEOUT - 1);

    logic          init_slow_q, init_slow_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        done        = init_slow_q && init_slow_done;
        err         = init_slow_q && !init_slow_done && (cnt_q == LAST);
        init_slow_d = init_slow_q;
        cnt_d       = cnt_q;
        if (start) begin
            init_slow_d = 1'b1;
            cnt_d       = '0;
        end else if (done || err) begin
            init_slow_d = 1'b0;
        end else if (init_slow_q) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_slow_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            init_slow_q <= init_slow_d;
            cnt_q       <= cnt_d;
        end
    end

    assign init_slow = init_slow_q;

endmodule

// File: rtl/anton_neopixel_frame_scheduler.sv
// Frame-level sequencer for the NeoPixel stream: init handshake, run enable,
// frame counting and frame-boundary bank swapping.
module anton_neopixel_frame_scheduler
    import anton_neopixel_frame_scheduler_pkg::*;
#(
    parameter int FRAME_CNT_BITS = FRAME_CNT_BITS_DEFAULT,
    parameter int INIT_TIMEOUT   = INIT_TIMEOUT_DEFAULT
) (
    input  logic                      clk6_4mhz,
    input  logic                      reset,
    input  logic                      cmd_start,
    input  logic                      cmd_stop,
    input  logic                      cmd_swap,
    input  logic                      reg_ctrl_loop,
    input  logic [FRAME_CNT_BITS-1:0] reg_frame_limit,
    input  logic                      stream_pixel_of,
    input  logic                      stream_sync_of,
    input  logic                      initSlowDone,
    output logic                      initSlow,
    output logic                      reg_ctrl_run,
    output logic                      bank_sel,
    output logic                      busy,
    output logic                      frame_done,
    output logic [FRAME_CNT_BITS-1:0] frame_count,
    output logic                      init_err
);

    localparam logic [FRAME_CNT_BITS-1:0] ONE = FRAME_CNT_BITS'(1);

    sched_state_e              state_q, state_d;
    logic                      run_q, run_d;
    logic                      bank_q, bank_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;
    logic                      stop_pend_q, stop_pend_d;
    logic                      swap_pend_q, swap_pend_d;
    logic [FRAME_CNT_BITS-1:0] count_q, count_d;
    logic [FRAME_CNT_BITS-1:0] count_inc, limit_eff;
    logic                      limit_hit, swap_req, stop_req;
    logic                      hs_start, hs_done, hs_err;

    anton_neopixel_init_handshake #(
        .INIT_TIMEOUT(INIT_TIMEOUT)
    ) u_init (
        .clk           (clk6_4mhz),
        .rst           (reset),
        .start         (hs_start),
        .init_slow_done(initSlowDone),
        .init_slow     (initSlow),
        .done          (hs_done),
        .err           (hs_err)
    );

    // Requests arriving on the boundary cycle itself still take effect.
    always_comb begin
        count_inc = (&count_q) ? count_q : count_q + ONE;
        limit_eff = (reg_frame_limit == '0) ? ONE : reg_frame_limit;
        limit_hit = !reg_ctrl_loop && (count_inc >= limit_eff);
        swap_req  = swap_pend_q || cmd_swap;
        stop_req  = stop_pend_q || cmd_stop;
    end

    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        bank_d      = bank_q;
        done_d      = 1'b0;
        err_d       = err_q;
        count_d     = count_q;
        stop_pend_d = stop_req;
        swap_pend_d = swap_req;
        hs_start    = 1'b0;
        unique case (state_q)
            ENUM_SCHED_IDLE: begin
                stop_pend_d = 1'b0;
                if (swap_req) begin
                    bank_d      = ~bank_q;
                    swap_pend_d = 1'b0;
                end
                if (cmd_start) begin
                    state_d     = ENUM_SCHED_INIT;
                    hs_start    = 1'b1;
                    count_d     = '0;
                    err_d       = 1'b0;
                    stop_pend_d = cmd_stop;
                end
            end
            ENUM_SCHED_INIT: begin
                if (hs_done) begin
                    state_d = ENUM_SCHED_STREAM;
                    run_d   = 1'b1;
                end else if (hs_err) begin
                    state_d     = ENUM_SCHED_IDLE;
                    err_d       = 1'b1;
                    stop_pend_d = 1'b0;
                end
            end
            ENUM_SCHED_STREAM: begin
                if (stream_pixel_of) state_d = ENUM_SCHED_LATCH;
            end
            ENUM_SCHED_LATCH: begin
                if (stream_sync_of) begin
                    done_d  = 1'b1;
                    count_d = count_inc;
                    if (swap_req) begin
                        bank_d      = ~bank_q;
                        swap_pend_d = 1'b0;
                    end
                    if (stop_req || limit_hit) begin
                        run_d   = 1'b0;
                        state_d = ENUM_SCHED_STOPPING;
                    end else begin
                        state_d = ENUM_SCHED_STREAM;
                    end
                end
            end
            ENUM_SCHED_STOPPING: begin
                state_d     = ENUM_SCHED_IDLE;
                run_d       = 1'b0;
                stop_pend_d = 1'b0;
            end
            default: begin
                state_d = ENUM_SCHED_IDLE;
                run_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk6_4mhz or posedge reset) begin
        if (reset) begin
            state_q     <= ENUM_SCHED_IDLE;
            run_q       <= 1'b0;
            bank_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            count_q     <= '0;
            stop_pend_q <= 1'b0;
            swap_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            bank_q      <= bank_d;
            done_q      <= done_d;
            err_q       <= err_d;
            count_q     <= count_d;
            stop_pend_q <= stop_pend_d;
            swap_pend_q <= swap_pend_d;
        end
    end

    assign reg_ctrl_run = run_q;
    assign bank_sel     = bank_q;
    assign busy         = (state_q != ENUM_SCHED_IDLE);
    assign frame_done   = done_q;
    assign frame_count  = count_q;
    assign init_err     = err_q;

endmodule

// File: tb/tb_anton_neopixel_frame_scheduler.sv
// Directed-plus-random bench for the NeoPixel frame scheduler.
module tb_anton_neopixel_frame_scheduler;

    logic       clk6_4mhz       = 1'b0;
    logic       reset           = 1'b1;
    logic       cmd_start       = 1'b0;
    logic       cmd_stop        = 1'b0;
    logic       cmd_swap        = 1'b0;
    logic       reg_ctrl_loop   = 1'b0;
    logic [7:0] reg_frame_limit = 8'd0;
    logic       stream_pixel_of = 1'b0;
    logic       stream_sync_of  = 1'b0;
    logic       initSlowDone    = 1'b0;
    logic       initSlow;
    logic       reg_ctrl_run;
    logic       bank_sel;
    logic       busy;
    logic       frame_done;
    logic [7:0] frame_count;
    logic       init_err;

    always #5 clk6_4mhz = ~clk6_4mhz;

    anton_neopixel_frame_scheduler #(
        .FRAME_CNT_BITS(8),
        .INIT_TIMEOUT  (15)
    ) dut (
        .clk6_4mhz      (clk6_4mhz),
        .reset          (reset),
        .cmd_start      (cmd_start),
        .cmd_stop       (cmd_stop),
        .cmd_swap       (cmd_swap),
        .reg_ctrl_loop  (reg_ctrl_loop),
        .reg_frame_limit(reg_frame_limit),
        .stream_pixel_of(stream_pixel_of),
        .stream_sync_of (stream_sync_of),
        .initSlowDone   (initSlowDone),
        .initSlow       (initSlow),
        .reg_ctrl_run   (reg_ctrl_run),
        .bank_sel       (bank_sel),
        .busy           (busy),
        .frame_done     (frame_done),
        .frame_count    (frame_count),
        .init_err       (init_err)
    );

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model: frames completed, expected bank, outstanding requests.
    int m_frames;
    int m_limit;
    bit m_loop;
    bit m_bank = 1'b0;
    bit m_swap_req = 1'b0;
    bit m_stop_req;

    task automatic tick();
        @(posedge clk6_4mhz);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_ack(input int delay, input bit with_stop);
        cmd_start = 1'b1;
        cmd_stop  = with_stop;
        tick();
        cmd_start = 1'b0;
        cmd_stop  = 1'b0;
        check("start_busy", busy, 1);
        check("start_initslow", initSlow, 1);
        check("start_err_clr", init_err, 0);
        check("start_cnt_clr", frame_count, 0);
        for (int i = 0; i < delay; i++) begin
            tick();
            check("init_hold", initSlow, 1);
            check("init_norun", reg_ctrl_run, 0);
        end
        initSlowDone = 1'b1;
        tick();
        initSlowDone = 1'b0;
        check("ack_initslow_low", initSlow, 0);
        check("ack_run", reg_ctrl_run, 1);
    endtask

    task automatic do_frame(input int stop_at, input int swap_at,
                            output bit stopped);
        int  p;
        int  s;
        int  f;
        int  lim;
        bit  exp_stop;
        p = $urandom_range(1, 5);
        s = $urandom_range(0, 3);
        f = m_frames + 1;
        for (int i = 0; i < p; i++) begin
            stream_sync_of = (i == 0);
            if (i == 0 && f == stop_at) begin
                cmd_stop   = 1'b1;
                m_stop_req = 1'b1;
            end
            if (i == 0 && f == swap_at) begin
                cmd_swap   = 1'b1;
                m_swap_req = 1'b1;
            end
            tick();
            stream_sync_of = 1'b0;
            cmd_stop       = 1'b0;
            cmd_swap       = 1'b0;
        end
        check("stream_run", reg_ctrl_run, 1);
        check("stream_no_done", frame_done, 0);
        stream_pixel_of = 1'b1;
        tick();
        for (int i = 0; i < s; i++) begin
            check("latch_no_done", frame_done, 0);
            check("latch_run", reg_ctrl_run, 1);
            tick();
        end
        stream_pixel_of = 1'b0;
        check("bank_before_sync", bank_sel, m_bank);
        stream_sync_of = 1'b1;
        tick();
        stream_sync_of = 1'b0;
        m_frames++;
        if (m_swap_req) begin
            m_bank     = ~m_bank;
            m_swap_req = 1'b0;
        end
        lim      = (m_limit == 0) ? 1 : m_limit;
        exp_stop = m_stop_req || (!m_loop && m_frames >= lim);
        check("sync_done", frame_done, 1);
        check("sync_count", frame_count, (m_frames > 255) ? 255 : m_frames);
        check("sync_bank", bank_sel, m_bank);
        check("sync_run", reg_ctrl_run, !exp_stop);
        check("sync_busy", busy, 1);
        if (exp_stop) begin
            tick();
            check("stop_idle", busy, 0);
            check("stop_norun", reg_ctrl_run, 0);
            check("stop_done_low", frame_done, 0);
        end
        stopped = exp_stop;
    endtask

    task automatic run_job(input bit loop, input int limit, input bit with_stop,
                           input int stop_at, input int swap_at,
                           input int delay, output int nframes);
        bit stopped;
        reg_ctrl_loop   = loop;
        reg_frame_limit = 8'(limit);
        m_loop          = loop;
        m_limit         = limit;
        m_frames        = 0;
        m_stop_req      = with_stop;
        stopped         = 1'b0;
        start_ack(delay, with_stop);
        while (!stopped && m_frames < 300) do_frame(stop_at, swap_at, stopped);
        check("job_terminates", stopped, 1);
        nframes = m_frames;
    endtask

    initial begin
        int n;
        int lim;

        repeat (2) tick();
        check("rst_initslow", initSlow, 0);
        check("rst_run", reg_ctrl_run, 0);
        check("rst_bank", bank_sel, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_count", frame_count, 0);
        check("rst_err", init_err, 0);
        reset = 1'b0;
        tick();
        check("idle_after_rst", busy, 0);

        run_job(1'b0, 3, 1'b0, 0, 0, 2, n);
        check("t1_frames", n, 3);
        check("t1_count", frame_count, 3);

        cmd_stop = 1'b1;
        tick();
        cmd_stop = 1'b0;
        check("idle_stop_ignored", busy, 0);

        run_job(1'b1, $urandom_range(0, 255), 1'b0, 2, 0,
                $urandom_range(0, 5), n);
        check("t2_frames", n, 2);

        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        for (int i = 0; i < 14; i++) begin
            check("to_wait_err", init_err, 0);
            check("to_wait_initslow", initSlow, 1);
            check("to_wait_norun", reg_ctrl_run, 0);
            tick();
        end
        tick();
        check("to_err", init_err, 1);
        check("to_initslow", initSlow, 0);
        check("to_idle", busy, 0);
        check("to_norun", reg_ctrl_run, 0);
        run_job(1'b0, 1, 1'b0, 0, 0, 1, n);
        check("to_recover_frames", n, 1);

        run_job(1'b1, 0, 1'b0, 2, 1, 1, n);
        check("t4_frames", n, 2);
        cmd_swap = 1'b1;
        tick();
        cmd_swap = 1'b0;
        m_bank = ~m_bank;
        check("idle_swap", bank_sel, m_bank);

        run_job(1'b0, 0, 1'b0, 0, 0, 0, n);
        check("limit0_frames", n, 1);
        run_job(1'b1, 7, 1'b1, 0, 0, 3, n);
        check("start_stop_frames", n, 1);

        repeat (4) begin
            lim = $urandom_range(1, 4);
            run_job(1'b0, lim, 1'b0, 0, $urandom_range(0, lim),
                    $urandom_range(0, 10), n);
            check("rand_frames", n, lim);
        end

        run_job(1'b1, 0, 1'b0, 258, 0, 0, n);
        check("sat_frames", n, 258);
        check("sat_count", frame_count, 255);

        if (!m_bank) begin
            cmd_swap = 1'b1;
            tick();
            cmd_swap = 1'b0;
            m_bank = 1'b1;
        end
        check("pre_rst_bank", bank_sel, 1);
        reg_ctrl_loop = 1'b1;
        m_loop        = 1'b1;
        m_limit       = 0;
        m_frames      = 0;
        m_stop_req    = 1'b0;
        start_ack(1, 1'b0);
        begin
            bit st;
            do_frame(0, 0, st);
        end
        stream_pixel_of = 1'b1;
        tick();
        stream_pixel_of = 1'b0;
        check("pre_rst_count", frame_count, 1);
        #2 reset = 1'b1;
        #1;
        check("arst_run", reg_ctrl_run, 0);
        check("arst_initslow", initSlow, 0);
        check("arst_bank", bank_sel, 0);
        check("arst_count", frame_count, 0);
        check("arst_busy", busy, 0);
        stream_sync_of = 1'b1;
        tick();
        stream_sync_of = 1'b0;
        check("arst_no_done", frame_done, 0);
        reset = 1'b0;
        tick();
        check("post_rst_idle", busy, 0);
        check("post_rst_done", frame_done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asserts, n_fail);
        $finish;
    end

endmodule
